// File: rtl/shift_arbiter.sv
// -----------------------------------------------------------------------------
// shift_arbiter: round-robin sharing of one 32-bit shifter, registered response
// Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module shift_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_REQ-1:0]      i_req_valid,
  output logic [NUM_REQ-1:0]      o_req_ready,
  input  logic [2*NUM_REQ-1:0]    i_req_op,
  input  logic [5*NUM_REQ-1:0]    i_req_shamt,
  input  logic [32*NUM_REQ-1:0]   i_req_data,
  output logic                    o_rsp_valid,
  input  logic                    i_rsp_ready,
  output logic [ID_W-1:0]         o_rsp_id,
  output logic [31:0]             o_rsp_data,
  output logic                    o_rsp_err
);

  localparam int         PTR_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_ILL = 2'b01;
  localparam logic [1:0] OP_SRL = 2'b10;
  localparam logic [1:0] OP_SRA = 2'b11;

  typedef enum logic [0:0] {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

  state_t            r_state;
  logic [PTR_W-1:0]  r_rr_ptr;
  logic [ID_W-1:0]   r_rsp_id;
  logic [31:0]       r_rsp_data;
  logic              r_rsp_err;

  logic              w_can_accept;
  logic              w_any_valid;
  logic              w_hi_any;
  logic [PTR_W-1:0]  w_hi_win;
  logic [PTR_W-1:0]  w_lo_win;
  logic [PTR_W-1:0]  w_winner;
  logic              w_grant;
  logic [PTR_W-1:0]  w_ptr_next;
  logic [1:0]        w_op;
  logic [4:0]        w_shamt;
  logic [31:0]       w_data;
  logic [31:0]       w_shift;

  // Ready is gated by rst_n so nothing is accepted while reset is held.
  assign w_can_accept = rst_n & ((r_state == ST_EMPTY) | i_rsp_ready);
  assign w_any_valid  = |i_req_valid;
  assign w_grant      = w_any_valid & w_can_accept;

  // Round robin: lowest valid port at or above the pointer, else lowest valid port overall.
  always_comb begin
    w_hi_any = 1'b0;
    w_hi_win = '0;
    w_lo_win = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (i_req_valid[i]) begin
        w_lo_win = PTR_W'(i);
        if (PTR_W'(i) >= r_rr_ptr) begin
          w_hi_win = PTR_W'(i);
          w_hi_any = 1'b1;
        end
      end
    end
  end

  assign w_winner   = w_hi_any ? w_hi_win : w_lo_win;
  assign w_ptr_next = (w_winner == PTR_W'(NUM_REQ - 1)) ? '0 : w_winner + PTR_W'(1);

  always_comb begin
    o_req_ready = '0;
    w_op        = '0;
    w_shamt     = '0;
    w_data      = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_winner == PTR_W'(i)) begin
        o_req_ready[i] = w_grant;
        w_op           = i_req_op[i*2 +: 2];
        w_shamt        = i_req_shamt[i*5 +: 5];
        w_data         = i_req_data[i*32 +: 32];
      end
    end
  end

  always_comb begin
    w_shift = '0;
    case (w_op)
      OP_SLL:  w_shift = w_data << w_shamt;
      OP_SRL:  w_shift = w_data >> w_shamt;
      OP_SRA:  w_shift = $signed(w_data) >>> w_shamt;
      default: w_shift = '0;
    endcase
  end

  // A grant always loads the response slot; this also covers drain-and-refill with no bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_EMPTY;
      r_rr_ptr   <= '0;
      r_rsp_id   <= '0;
      r_rsp_data <= '0;
      r_rsp_err  <= 1'b0;
    end else begin
      if (w_grant) begin
        r_rr_ptr   <= w_ptr_next;
        r_rsp_id   <= ID_W'(w_winner);
        r_rsp_data <= w_shift;
        r_rsp_err  <= (w_op == OP_ILL);
      end
      case (r_state)
        ST_EMPTY: begin
          if (w_grant) begin
            r_state <= ST_FULL;
          end
        end
        ST_FULL: begin
          if (!w_grant && i_rsp_ready) begin
            r_state <= ST_EMPTY;
          end
        end
        default: r_state <= ST_EMPTY;
      endcase
    end
  end

  assign o_rsp_valid = (r_state == ST_FULL);
  assign o_rsp_id    = r_rsp_id;
  assign o_rsp_data  = r_rsp_data;
  assign o_rsp_err   = r_rsp_err;

endmodule

`default_nettype wire

// File: tb/tb_shift_arbiter.sv
// -----------------------------------------------------------------------------
// tb_shift_arbiter: directed and randomized checks of shift_arbiter
// Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module tb_shift_arbiter;

  localparam int NR  = 2;
  localparam int IDW = 1;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NR-1:0]     i_req_valid = '0;
  logic [NR-1:0]     o_req_ready;
  logic [2*NR-1:0]   i_req_op;
  logic [5*NR-1:0]   i_req_shamt;
  logic [32*NR-1:0]  i_req_data;
  logic              o_rsp_valid;
  logic              i_rsp_ready = 1'b0;
  logic [IDW-1:0]    o_rsp_id;
  logic [31:0]       o_rsp_data;
  logic              o_rsp_err;

  logic [1:0]  op_a  [NR];
  logic [4:0]  sh_a  [NR];
  logic [31:0] dat_a [NR];

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  bit          m_full;
  int          m_ptr;
  int          m_id;
  logic [31:0] m_data;
  bit          m_err;
  bit          m_grant;
  int          m_win;
  logic [NR-1:0] exp_ready;

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < NR; i++) begin
      i_req_op[i*2 +: 2]     = op_a[i];
      i_req_shamt[i*5 +: 5]  = sh_a[i];
      i_req_data[i*32 +: 32] = dat_a[i];
    end
  end

  shift_arbiter #(.NUM_REQ(NR), .ID_W(IDW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_req_valid (i_req_valid),
    .o_req_ready (o_req_ready),
    .i_req_op    (i_req_op),
    .i_req_shamt (i_req_shamt),
    .i_req_data  (i_req_data),
    .o_rsp_valid (o_rsp_valid),
    .i_rsp_ready (i_rsp_ready),
    .o_rsp_id    (o_rsp_id),
    .o_rsp_data  (o_rsp_data),
    .o_rsp_err   (o_rsp_err)
  );

  // Shift results from arithmetic: multiply/divide by powers of two.
  function automatic logic [31:0] ref_shift(input logic [1:0] op, input logic [4:0] sh,
                                            input logic [31:0] d);
    longint unsigned pw;
    longint unsigned prod;
    pw = 64'd1 << sh;
    case (op)
      2'b00: begin
        prod = 64'(d) * pw;
        return prod[31:0];
      end
      2'b10: return d / 32'(pw);
      2'b11: return d[31] ? ~((~d) / 32'(pw)) : d / 32'(pw);
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_reset();
    m_full  = 0;
    m_ptr   = 0;
    m_id    = 0;
    m_data  = '0;
    m_err   = 0;
    m_grant = 0;
    m_win   = 0;
  endtask

  task automatic set_port(input int p, input logic [1:0] op, input logic [4:0] sh,
                          input logic [31:0] d);
    op_a[p]  = op;
    sh_a[p]  = sh;
    dat_a[p] = d;
  endtask

  // Apply inputs after the falling edge and predict who should be granted.
  task automatic drive(input logic [NR-1:0] v, input logic rr);
    int p;
    @(negedge clk);
    i_req_valid = v;
    i_rsp_ready = rr;
    m_grant = 0;
    m_win   = 0;
    if (!m_full || rr) begin
      for (int k = 0; k < NR; k++) begin
        p = (m_ptr + k) % NR;
        if (!m_grant && v[p]) begin
          m_grant = 1;
          m_win   = p;
        end
      end
    end
    exp_ready = '0;
    if (m_grant) exp_ready[m_win] = 1'b1;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    if (m_grant) begin
      m_full = 1;
      m_id   = m_win;
      m_data = ref_shift(op_a[m_win], sh_a[m_win], dat_a[m_win]);
      m_err  = (op_a[m_win] == 2'b01);
      m_ptr  = (m_win + 1) % NR;
    end else if (i_rsp_ready) begin
      m_full = 0;
    end
    #1;
  endtask

  task automatic test_reset();
    model_reset();
    for (int i = 0; i < NR; i++) set_port(i, 2'b00, 5'd0, 32'h0);
    #3;
    n_tests++;
    if ({o_rsp_valid, o_rsp_err, o_req_ready} !== '0 || o_rsp_data !== 32'h0 || o_rsp_id !== '0) begin
      n_fail++;
      $display("FAIL reset_initial: valid=%b err=%b ready=%b data=%h id=%h, required all zero",
               o_rsp_valid, o_rsp_err, o_req_ready, o_rsp_data, o_rsp_id);
    end
    @(negedge clk);
    rst_n = 1'b1;
    set_port(0, 2'b00, 5'd4, 32'h80000010);
    drive(2'b01, 1'b0);
    tick();
    n_tests++;
    if (o_rsp_valid !== 1'b1 || o_rsp_data !== 32'h00000100) begin
      n_fail++;
      $display("FAIL reset_pre_fill: valid=%b data=%h, required 1 00000100", o_rsp_valid, o_rsp_data);
    end
    @(negedge clk);
    i_req_valid = 2'b01;
    i_rsp_ready = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    n_tests++;
    if ({o_rsp_valid, o_rsp_err, o_req_ready} !== '0 || o_rsp_data !== 32'h0 || o_rsp_id !== '0) begin
      n_fail++;
      $display("FAIL reset_async: valid=%b err=%b ready=%b data=%h id=%h, required all zero",
               o_rsp_valid, o_rsp_err, o_req_ready, o_rsp_data, o_rsp_id);
    end
    model_reset();
    i_req_valid = '0;
    @(negedge clk);
    rst_n = 1'b1;
    set_port(1, 2'b00, 5'd1, 32'h1);
    drive(2'b11, 1'b1);
    n_tests++;
    if (o_req_ready !== 2'b01) begin
      n_fail++;
      $display("FAIL reset_ptr_zero: ready=%b, required 01", o_req_ready);
    end
    tick();
  endtask

  task automatic test_single_ops();
    logic [1:0]  ops  [3];
    logic [31:0] want [3];
    ops[0] = 2'b00; want[0] = 32'h00000100;
    ops[1] = 2'b10; want[1] = 32'h08000001;
    ops[2] = 2'b11; want[2] = 32'hF8000001;
    for (int k = 0; k < 3; k++) begin
      set_port(0, ops[k], 5'd4, 32'h80000010);
      drive(2'b01, 1'b1);
      n_tests++;
      if (o_req_ready !== 2'b01) begin
        n_fail++;
        $display("FAIL single_ready op%0d: ready=%b, required 01", k, o_req_ready);
      end
      tick();
      n_tests++;
      if (o_rsp_valid !== 1'b1 || o_rsp_data !== want[k] || o_rsp_id !== '0 || o_rsp_err !== 1'b0) begin
        n_fail++;
        $display("FAIL single_rsp op%0d: valid=%b data=%h id=%h err=%b, required 1 %h 0 0",
                 k, o_rsp_valid, o_rsp_data, o_rsp_id, o_rsp_err, want[k]);
      end
    end
  endtask

  task automatic test_contention();
    int prev;
    set_port(0, 2'b00, 5'd1, 32'h10);
    set_port(1, 2'b10, 5'd1, 32'h10);
    prev = -1;
    for (int c = 0; c < 4; c++) begin
      drive(2'b11, 1'b1);
      n_tests++;
      if (o_req_ready !== exp_ready || m_win == prev) begin
        n_fail++;
        $display("FAIL contention_grant c%0d: ready=%b, required %b", c, o_req_ready, exp_ready);
      end
      prev = m_win;
      tick();
      n_tests++;
      if (o_rsp_valid !== 1'b1 || o_rsp_id !== IDW'(m_id) || o_rsp_data !== m_data) begin
        n_fail++;
        $display("FAIL contention_rsp c%0d: valid=%b id=%h data=%h, required 1 %0d %h",
                 c, o_rsp_valid, o_rsp_id, o_rsp_data, m_id, m_data);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0]    held_data;
    logic [IDW-1:0] held_id;
    set_port(0, 2'b00, 5'd3, 32'h0000_0005);
    set_port(1, 2'b11, 5'd2, 32'hF000_0000);
    drive(2'b01, 1'b1);
    tick();
    held_data = o_rsp_data;
    held_id   = o_rsp_id;
    n_tests++;
    if (held_data !== 32'h28 || held_id !== '0) begin
      n_fail++;
      $display("FAIL bp_fill: data=%h id=%h, required 00000028 0", held_data, held_id);
    end
    for (int c = 0; c < 3; c++) begin
      drive(2'b10, 1'b0);
      n_tests++;
      if (o_req_ready !== 2'b00) begin
        n_fail++;
        $display("FAIL bp_ready c%0d: ready=%b, required 00", c, o_req_ready);
      end
      tick();
      n_tests++;
      if (o_rsp_valid !== 1'b1 || o_rsp_data !== held_data || o_rsp_id !== held_id) begin
        n_fail++;
        $display("FAIL bp_hold c%0d: valid=%b data=%h id=%h, required 1 %h %h",
                 c, o_rsp_valid, o_rsp_data, o_rsp_id, held_data, held_id);
      end
    end
    drive(2'b10, 1'b1);
    n_tests++;
    if (o_req_ready !== 2'b10) begin
      n_fail++;
      $display("FAIL bp_release_ready: ready=%b, required 10", o_req_ready);
    end
    tick();
    n_tests++;
    if (o_rsp_valid !== 1'b1 || o_rsp_id !== IDW'(1) || o_rsp_data !== 32'hFC00_0000) begin
      n_fail++;
      $display("FAIL bp_release_rsp: valid=%b id=%h data=%h, required 1 1 fc000000",
               o_rsp_valid, o_rsp_id, o_rsp_data);
    end
  endtask

  task automatic test_illegal();
    set_port(0, 2'b01, 5'd5, 32'hFFFF_FFFF);
    drive(2'b01, 1'b1);
    tick();
    n_tests++;
    if (o_rsp_valid !== 1'b1 || o_rsp_data !== 32'h0 || o_rsp_err !== 1'b1) begin
      n_fail++;
      $display("FAIL illegal_op: valid=%b data=%h err=%b, required 1 00000000 1",
               o_rsp_valid, o_rsp_data, o_rsp_err);
    end
    set_port(0, 2'b00, 5'd1, 32'h0000_0001);
    drive(2'b01, 1'b1);
    tick();
    n_tests++;
    if (o_rsp_data !== 32'h2 || o_rsp_err !== 1'b0) begin
      n_fail++;
      $display("FAIL illegal_follow: data=%h err=%b, required 00000002 0", o_rsp_data, o_rsp_err);
    end
  endtask

  task automatic test_boundary();
    logic [1:0]  ops  [3];
    logic [31:0] want [3];
    ops[0] = 2'b11; want[0] = 32'hFFFF_FFFF;
    ops[1] = 2'b10; want[1] = 32'h0000_0001;
    ops[2] = 2'b00; want[2] = 32'h0000_0000;
    for (int k = 0; k < 3; k++) begin
      set_port(1, ops[k], 5'd31, 32'h8000_0000);
      drive(2'b10, 1'b1);
      tick();
      n_tests++;
      if (o_rsp_data !== want[k] || o_rsp_id !== IDW'(1)) begin
        n_fail++;
        $display("FAIL boundary_sh31 op%0d: data=%h id=%h, required %h 1", k, o_rsp_data, o_rsp_id, want[k]);
      end
      set_port(1, ops[k], 5'd0, 32'h8000_0000);
      drive(2'b10, 1'b1);
      tick();
      n_tests++;
      if (o_rsp_data !== 32'h8000_0000) begin
        n_fail++;
        $display("FAIL boundary_sh0 op%0d: data=%h, required 80000000", k, o_rsp_data);
      end
    end
  endtask

  task automatic test_random();
    logic [NR-1:0] vld;
    logic [NR-1:0] last_rdy;
    logic [31:0]   d;
    logic          rr;
    last_rdy = '0;
    for (int c = 0; c < 300; c++) begin
      for (int p = 0; p < NR; p++) begin
        if (!i_req_valid[p] || last_rdy[p]) begin
          vld[p] = ($urandom_range(0, 9) < 7);
          case ($urandom_range(0, 3))
            0:       d = 32'h8000_0000;
            1:       d = 32'hFFFF_FFFF;
            default: d = $urandom;
          endcase
          set_port(p, 2'($urandom), 5'($urandom), d);
        end else begin
          vld[p] = 1'b1;
        end
      end
      rr = ($urandom_range(0, 3) != 0);
      drive(vld, rr);
      n_tests++;
      if (o_req_ready !== exp_ready) begin
        n_fail++;
        $display("FAIL random_ready c%0d: ready=%b, required %b", c, o_req_ready, exp_ready);
      end
      last_rdy = exp_ready;
      tick();
      n_tests++;
      if (o_rsp_valid !== m_full ||
          (m_full && (o_rsp_id !== IDW'(m_id) || o_rsp_data !== m_data || o_rsp_err !== m_err))) begin
        n_fail++;
        $display("FAIL random_rsp c%0d: valid=%b id=%h data=%h err=%b, required %b %0d %h %b",
                 c, o_rsp_valid, o_rsp_id, o_rsp_data, o_rsp_err, m_full, m_id, m_data, m_err);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_ops();
    test_contention();
    test_backpressure();
    test_illegal();
    test_boundary();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

endmodule

`default_nettype wire
